// File: rtl/fp_exp_align_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fp_exp_align_pipe
// Brief   : FP adder front end - exponent compare, mantissa align with G/R/S,
//           two-stage valid/ready pipeline, saturation event counter.
// Revision: 1.0
// ============================================================================
module fp_exp_align_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 24,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W-1:0]     exp_a,
  input  logic [MAN_W-1:0]     man_a,
  input  logic [EXP_W-1:0]     exp_b,
  input  logic [MAN_W-1:0]     man_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 swap,
  output logic [EXP_W-1:0]     exp_big,
  output logic [MAN_W-1:0]     man_big,
  output logic [MAN_W+2:0]     man_small,
  output logic [SHAMT_W-1:0]   shamt,
  output logic [CNT_W-1:0]     sat_cnt
);

  localparam int                 c_ext_w     = MAN_W + 3;
  localparam int                 c_sat_max   = (1 << SHAMT_W) - 1;
  localparam logic [EXP_W-1:0]   c_sat_max_e = EXP_W'(c_sat_max);
  localparam logic [SHAMT_W-1:0] c_sat_max_s = SHAMT_W'(c_sat_max);

  // Stage 1 registers: compare result plus the still-unshifted small mantissa
  logic               s1_valid_q,     s1_valid_d;
  logic               s1_swap_q,      s1_swap_d;
  logic [EXP_W-1:0]   s1_exp_big_q,   s1_exp_big_d;
  logic [MAN_W-1:0]   s1_man_big_q,   s1_man_big_d;
  logic [MAN_W-1:0]   s1_man_small_q, s1_man_small_d;
  logic [SHAMT_W-1:0] s1_shamt_q,     s1_shamt_d;

  // Stage 2 registers drive the outputs directly
  logic               out_valid_q,    out_valid_d;
  logic               swap_q,         swap_d;
  logic [EXP_W-1:0]   exp_big_q,      exp_big_d;
  logic [MAN_W-1:0]   man_big_q,      man_big_d;
  logic [c_ext_w-1:0] man_small_q,    man_small_d;
  logic [SHAMT_W-1:0] shamt_q,        shamt_d;
  logic [CNT_W-1:0]   sat_cnt_q,      sat_cnt_d;

  logic               w_s2_adv;
  logic               w_s1_adv;
  logic               w_accept;
  logic               w_swap;
  logic [EXP_W-1:0]   w_exp_small;
  logic [EXP_W-1:0]   w_exp_big;
  logic [EXP_W-1:0]   w_diff;
  logic               w_sat;
  logic [c_ext_w-1:0] w_ext;
  logic [c_ext_w-1:0] w_shifted;
  logic [c_ext_w-1:0] w_lost;
  logic [c_ext_w-1:0] w_aligned;

  assign w_s2_adv = !out_valid_q || out_ready;
  assign w_s1_adv = !s1_valid_q || w_s2_adv;
  assign w_accept = in_valid && w_s1_adv;

  // Exponent compare; ties keep A as the big operand
  always_comb begin
    w_swap      = (exp_b > exp_a);
    w_exp_big   = w_swap ? exp_b : exp_a;
    w_exp_small = w_swap ? exp_a : exp_b;
    w_diff      = w_exp_big - w_exp_small;
    w_sat       = (w_diff > c_sat_max_e);
  end

  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_swap_d      = s1_swap_q;
    s1_exp_big_d   = s1_exp_big_q;
    s1_man_big_d   = s1_man_big_q;
    s1_man_small_d = s1_man_small_q;
    s1_shamt_d     = s1_shamt_q;
    if (w_s1_adv) begin
      s1_valid_d = in_valid;
    end
    if (w_accept) begin
      s1_swap_d      = w_swap;
      s1_exp_big_d   = w_exp_big;
      s1_man_big_d   = w_swap ? man_b : man_a;
      s1_man_small_d = w_swap ? man_a : man_b;
      s1_shamt_d     = w_sat ? c_sat_max_s : w_diff[SHAMT_W-1:0];
    end
  end

  // Alignment shift; everything shifted past bit 0 folds into the sticky bit
  always_comb begin
    w_ext     = {s1_man_small_q, 3'b000};
    w_shifted = w_ext >> s1_shamt_q;
    w_lost    = w_ext & ~({c_ext_w{1'b1}} << s1_shamt_q);
    if (32'(s1_shamt_q) >= c_ext_w) begin
      w_aligned = {{(c_ext_w-1){1'b0}}, |s1_man_small_q};
    end else begin
      w_aligned = {w_shifted[c_ext_w-1:1], w_shifted[0] | (|w_lost)};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    swap_d      = swap_q;
    exp_big_d   = exp_big_q;
    man_big_d   = man_big_q;
    man_small_d = man_small_q;
    shamt_d     = shamt_q;
    if (w_s2_adv) begin
      out_valid_d = s1_valid_q;
    end
    if (w_s2_adv && s1_valid_q) begin
      swap_d      = s1_swap_q;
      exp_big_d   = s1_exp_big_q;
      man_big_d   = s1_man_big_q;
      man_small_d = w_aligned;
      shamt_d     = s1_shamt_q;
    end
  end

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (w_accept && w_sat && (sat_cnt_q != {CNT_W{1'b1}})) begin
      sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      s1_swap_q      <= 1'b0;
      s1_exp_big_q   <= '0;
      s1_man_big_q   <= '0;
      s1_man_small_q <= '0;
      s1_shamt_q     <= '0;
      out_valid_q    <= 1'b0;
      swap_q         <= 1'b0;
      exp_big_q      <= '0;
      man_big_q      <= '0;
      man_small_q    <= '0;
      shamt_q        <= '0;
      sat_cnt_q      <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_swap_q      <= s1_swap_d;
      s1_exp_big_q   <= s1_exp_big_d;
      s1_man_big_q   <= s1_man_big_d;
      s1_man_small_q <= s1_man_small_d;
      s1_shamt_q     <= s1_shamt_d;
      out_valid_q    <= out_valid_d;
      swap_q         <= swap_d;
      exp_big_q      <= exp_big_d;
      man_big_q      <= man_big_d;
      man_small_q    <= man_small_d;
      shamt_q        <= shamt_d;
      sat_cnt_q      <= sat_cnt_d;
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = out_valid_q;
  assign swap      = swap_q;
  assign exp_big   = exp_big_q;
  assign man_big   = man_big_q;
  assign man_small = man_small_q;
  assign shamt     = shamt_q;
  assign sat_cnt   = sat_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_exp_align_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_exp_align_pipe
// Brief   : Randomized + directed bench with an arithmetic scoreboard model.
// Revision: 1.0
// ============================================================================
module tb_fp_exp_align_pipe;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 24;
  localparam int SHAMT_W = 5;
  localparam int CNT_W   = 16;
  localparam int EXT_W   = MAN_W + 3;
  localparam int SAT_MAX = (1 << SHAMT_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [EXP_W-1:0]   exp_a = '0;
  logic [MAN_W-1:0]   man_a = '0;
  logic [EXP_W-1:0]   exp_b = '0;
  logic [MAN_W-1:0]   man_b = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               swap;
  logic [EXP_W-1:0]   exp_big;
  logic [MAN_W-1:0]   man_big;
  logic [EXT_W-1:0]   man_small;
  logic [SHAMT_W-1:0] shamt;
  logic [CNT_W-1:0]   sat_cnt;

  fp_exp_align_pipe #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .SHAMT_W(SHAMT_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .exp_a(exp_a), .man_a(man_a), .exp_b(exp_b), .man_b(man_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .swap(swap), .exp_big(exp_big), .man_big(man_big),
    .man_small(man_small), .shamt(shamt), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic               swap;
    logic [EXP_W-1:0]   exp_big;
    logic [MAN_W-1:0]   man_big;
    logic [EXT_W-1:0]   man_small;
    logic [SHAMT_W-1:0] shamt;
    logic               sat;
    int                 avail;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   ecnt = 0;
  int   m_cnt = 0;
  int   acc_total = 0;
  int   fire_total = 0;
  bit   last_acc = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Alignment expressed as integer division/remainder by a power of two
  function automatic exp_t model(input logic [EXP_W-1:0] ea, input logic [MAN_W-1:0] ma,
                                 input logic [EXP_W-1:0] eb, input logic [MAN_W-1:0] mb);
    exp_t             r;
    int               diff;
    int               sh;
    longint           ext;
    longint           kept;
    longint           lost;
    logic [MAN_W-1:0] msm;
    r.swap    = (eb > ea);
    r.exp_big = r.swap ? eb : ea;
    r.man_big = r.swap ? mb : ma;
    msm       = r.swap ? ma : mb;
    diff      = r.swap ? (int'(eb) - int'(ea)) : (int'(ea) - int'(eb));
    r.sat     = (diff > SAT_MAX);
    sh        = r.sat ? SAT_MAX : diff;
    r.shamt   = SHAMT_W'(sh);
    if (sh >= EXT_W) begin
      r.man_small = (msm != 0) ? EXT_W'(1) : EXT_W'(0);
    end else begin
      ext  = longint'(msm) * 8;
      kept = ext / (longint'(1) << sh);
      lost = ext % (longint'(1) << sh);
      r.man_small = EXT_W'(kept) | ((lost != 0) ? EXT_W'(1) : EXT_W'(0));
    end
    r.avail = 0;
    return r;
  endfunction

  // One clock: drive at negedge, check against the model, update the model
  task automatic cycle(input logic iv, input logic [EXP_W-1:0] ea, input logic [MAN_W-1:0] ma,
                       input logic [EXP_W-1:0] eb, input logic [MAN_W-1:0] mb, input logic ordy);
    exp_t e;
    bit   exp_ov;
    bit   exp_ir;
    @(negedge clk);
    in_valid  = iv;
    exp_a     = ea;
    man_a     = ma;
    exp_b     = eb;
    man_b     = mb;
    out_ready = ordy;
    #1;
    check("sat_cnt", 64'(sat_cnt), 64'(m_cnt));
    exp_ov = (q.size() > 0) && (ecnt >= q[0].avail);
    exp_ir = !((q.size() == 2) && !ordy);
    check("out_valid", 64'(out_valid), 64'(exp_ov));
    check("in_ready", 64'(in_ready), 64'(exp_ir));
    if (exp_ov) begin
      if (out_valid) begin
        check("swap",      64'(swap),      64'(q[0].swap));
        check("exp_big",   64'(exp_big),   64'(q[0].exp_big));
        check("man_big",   64'(man_big),   64'(q[0].man_big));
        check("man_small", 64'(man_small), 64'(q[0].man_small));
        check("shamt",     64'(shamt),     64'(q[0].shamt));
      end
      if (ordy) begin
        void'(q.pop_front());
        fire_total++;
      end
    end
    last_acc = iv && exp_ir;
    if (last_acc) begin
      e       = model(ea, ma, eb, mb);
      e.avail = ecnt + 2;
      q.push_back(e);
      acc_total++;
      if (e.sat && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, '0, '0, '0, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    m_cnt = 0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_sat_cnt",   64'(sat_cnt),   64'(0));
    check("rst_data",      64'({swap, exp_big, man_small, shamt}), 64'(0));
    check("rst_man_big",   64'(man_big),   64'(0));
  endtask

  task automatic rand_pair(output logic [EXP_W-1:0] ea, output logic [MAN_W-1:0] ma,
                           output logic [EXP_W-1:0] eb, output logic [MAN_W-1:0] mb);
    int d;
    ea = EXP_W'($urandom);
    case ($urandom_range(0, 3))
      0:       d = 0;
      1:       d = int'($urandom_range(0, 40));
      2:       d = int'($urandom_range(0, 255));
      default: d = int'($urandom_range(24, 33));
    endcase
    eb = $urandom_range(0, 1) ? EXP_W'(int'(ea) + d) : EXP_W'(int'(ea) - d);
    ma = MAN_W'($urandom) | ($urandom_range(0, 7) != 0 ? MAN_W'(24'h800000) : MAN_W'(0));
    mb = ($urandom_range(0, 15) == 0) ? MAN_W'(0) : (MAN_W'($urandom) | MAN_W'(24'h800000));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic [EXP_W-1:0] pe_a[3];
    logic [EXP_W-1:0] pe_b[3];
    logic [MAN_W-1:0] pm_a[3];
    logic [MAN_W-1:0] pm_b[3];
    int idx;
    int a0;
    int f0;

    do_reset();

    // Small shift with sticky, and two-edge latency
    cycle(1'b1, 8'h85, 24'h9ABCDE, 8'h80, 24'h800001, 1'b1);
    idle(1'b1);
    check("t1_lat_early", 64'(out_valid), 64'(0));
    idle(1'b1);
    check("t1_lat", 64'(out_valid), 64'(1));
    check("t1_swap", 64'(swap), 64'(0));
    check("t1_shamt", 64'(shamt), 64'(5));
    check("t1_man_small", 64'(man_small), 64'(27'h200001));

    // Saturated shift with swap
    cycle(1'b1, 8'h10, 24'h800000, 8'h70, 24'h123456, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("t2_swap", 64'(swap), 64'(1));
    check("t2_exp_big", 64'(exp_big), 64'(8'h70));
    check("t2_shamt", 64'(shamt), 64'(31));
    check("t2_man_small", 64'(man_small), 64'(27'h1));
    check("t2_sat_cnt", 64'(sat_cnt), 64'(1));

    // Equal exponents
    cycle(1'b1, 8'h7F, 24'hABCDEF, 8'h7F, 24'hC00000, 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("t3_swap", 64'(swap), 64'(0));
    check("t3_shamt", 64'(shamt), 64'(0));
    check("t3_man_small", 64'(man_small), 64'(27'h6000000));

    // Stall: 3 pairs offered while out_ready is low for 4 cycles
    for (int i = 0; i < 3; i++) begin
      rand_pair(pe_a[i], pm_a[i], pe_b[i], pm_b[i]);
    end
    idx = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, pe_a[idx], pm_a[idx], pe_b[idx], pm_b[idx], 1'b0);
      if (last_acc) idx++;
    end
    check("stall_accepted", 64'(idx), 64'(2));
    check("stall_in_ready", 64'(in_ready), 64'(0));
    f0 = fire_total;
    for (int i = 0; i < 8; i++) begin
      if (idx < 3) begin
        cycle(1'b1, pe_a[idx], pm_a[idx], pe_b[idx], pm_b[idx], 1'b1);
        if (last_acc) idx++;
      end else begin
        idle(1'b1);
      end
    end
    check("stall_all_accepted", 64'(idx), 64'(3));
    check("stall_released", 64'(fire_total - f0), 64'(3));

    // Reset with both stages full and stalled
    cycle(1'b1, 8'hFF, 24'h800000, 8'h00, 24'hFFFFFF, 1'b0);
    cycle(1'b1, 8'h40, 24'h900000, 8'h41, 24'hA00000, 1'b0);
    idle(1'b0);
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_sat_cnt_nz", 64'(sat_cnt != 0), 64'(1));
    do_reset();

    // Back-to-back with out_ready held high
    a0 = acc_total;
    f0 = fire_total;
    for (int i = 0; i < 10; i++) begin
      rand_pair(ea, ma, eb, mb);
      cycle(1'b1, ea, ma, eb, mb, 1'b1);
    end
    check("b2b_accepted", 64'(acc_total - a0), 64'(10));
    idle(1'b1);
    idle(1'b1);
    check("b2b_released", 64'(fire_total - f0), 64'(10));

    // Randomized traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      rand_pair(ea, ma, eb, mb);
      cycle(($urandom_range(0, 3) != 0), ea, ma, eb, mb, ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
    end
    check("drain_out_valid", 64'(out_valid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
